// File: rtl/uart_pkg.sv
// Shared defaults and state encoding for the UART transmit buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    localparam int DATA_W_DEF      = 8;
    localparam int ADDR_W_DEF      = 4;
    localparam int TIMEOUT_CYC_DEF = 200000;

    // Launch controller states: IDLE looks for a byte, WAIT holds until the transmitter finishes
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } buf_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Circular byte FIFO with registered count, full/empty flags and an overflow pulse.
// Latency: a push is visible in count/empty after one edge; rd_data shows mem[rd_ptr] combinationally.
// Backpressure: full refuses pushes; a refused push pulses overflow_tick for one cycle.
module uart_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow_tick
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              push, pop;

    // A full FIFO rejects the push even if a pop frees a slot on the same edge
    assign push = wr_en && !full;
    assign pop  = rd_en && !empty;

    assign full          = (count_q == (ADDR_W+1)'(DEPTH));
    assign empty         = (count_q == '0);
    assign count         = count_q;
    assign overflow_tick = overflow_q;
    assign rd_data       = mem_q[rd_ptr_q];

    // Pointer, count and overflow next-state
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = wr_en && full;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    // Control registers; storage itself is deliberately left out of reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Byte storage write port
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// Buffers system bytes and launches them one at a time into the UART transmitter (macro UART_TX_BUFFER_TIMEOUT_EN adds a watchdog).
// Latency: push into empty idle buffer at edge n -> tx_start after edge n+1; next launch 2 edges after tx_done_tick.
// Backpressure: full blocks writers (overflow_tick on a dropped push); launches wait for tx_done_tick.
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
`ifdef UART_TX_BUFFER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow_tick,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_done_tick,
    output logic              busy
`ifdef UART_TX_BUFFER_TIMEOUT_EN
    ,
    output logic              timeout_tick
`endif
);

    buf_state_t        state_q, state_d;
    logic              tx_start_q, tx_start_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              launch;
    logic              wdog_expire;

    uart_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .rd_en         (launch),
        .rd_data       (fifo_rd_data),
        .full          (full),
        .empty         (empty),
        .count         (count),
        .overflow_tick (overflow_tick)
    );

    // A launch pops the head byte whenever the controller is idle and data is waiting
    assign launch = (state_q == IDLE) && !empty;

`ifdef UART_TX_BUFFER_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYC + 1);

    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              timeout_q, timeout_d;

    // Expiry only counts when the transmitter has not finished on that same edge
    assign wdog_expire  = (state_q == WAIT) && !tx_done_tick &&
                          (wdog_q == WDOG_W'(TIMEOUT_CYC - 1));
    assign timeout_tick = timeout_q;

    // Watchdog: cleared on launch, counts every cycle spent in WAIT
    always_comb begin
        wdog_d    = wdog_q;
        timeout_d = wdog_expire;
        if (launch)                wdog_d = '0;
        else if (state_q == WAIT)  wdog_d = wdog_q + 1'b1;
    end

    // Watchdog registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end
`else
    assign wdog_expire = 1'b0;
`endif

    // State register plus registered launch outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // Next-state: launch moves to WAIT, completion (or watchdog expiry) returns to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (launch) state_d = WAIT;
            WAIT: if (tx_done_tick || wdog_expire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output next values: one-cycle start pulse, data held between launches
    always_comb begin
        tx_start_d = launch;
        tx_data_d  = launch ? fifo_rd_data : tx_data_q;
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign busy     = (state_q == WAIT);

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer with a scripted transmitter handshake.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercises full/overflow, simultaneous push/pop, and reset mid-transfer.
module tb_uart_tx_buffer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, empty, overflow_tick, tx_start, busy;
    logic [4:0] count;
    logic [7:0] tx_data;
    logic       tx_done_tick = 1'b0;
`ifdef UART_TX_BUFFER_TIMEOUT_EN
    logic       timeout_tick;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    uart_tx_buffer #(
        .DATA_W (8),
        .ADDR_W (4)
`ifdef UART_TX_BUFFER_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (50)
`endif
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .full          (full),
        .empty         (empty),
        .count         (count),
        .overflow_tick (overflow_tick),
        .tx_start      (tx_start),
        .tx_data       (tx_data),
        .tx_done_tick  (tx_done_tick),
        .busy          (busy)
`ifdef UART_TX_BUFFER_TIMEOUT_EN
        ,
        .timeout_tick  (timeout_tick)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    // Called one cycle after a launch: let the transmitter run, return done,
    // then expect either the next launch 2 edges later or an idle, drained buffer.
    task automatic finish_tx(input logic [7:0] exp_byte, input bit has_next);
        repeat (18) tick();
        chk("busy_during_tx", busy, 1);
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
        chk("busy_after_done", busy, 0);
        chk("no_start_on_reentry", tx_start, 0);
        tick();
        if (has_next) begin
            chk("launch_start", tx_start, 1);
            chk("launch_data", tx_data, exp_byte);
            tick();
            chk("start_pulse_width", tx_start, 0);
            chk("busy_after_launch", busy, 1);
        end else begin
            chk("idle_no_start", tx_start, 0);
            chk("data_held", tx_data, exp_byte);
            chk("drained_empty", empty, 1);
        end
    endtask

    initial begin
        // Reset values
        #2 reset = 1'b1;
        tick();
        tick();
        chk("rst_full", full, 0);
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_overflow", overflow_tick, 0);
        chk("rst_start", tx_start, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        tick();

        // Three bytes, in-order single-cycle launches
        push(8'h55);
        chk("t1_count_after_push", count, 1);
        chk("t1_no_start_yet", tx_start, 0);
        push(8'hA3);
        chk("t1_first_start", tx_start, 1);
        chk("t1_first_data", tx_data, 8'h55);
        chk("t1_pushpop_count", count, 1);
        push(8'h0F);
        chk("t1_pulse_end", tx_start, 0);
        chk("t1_busy", busy, 1);
        chk("t1_count2", count, 2);
        finish_tx(8'hA3, 1);
        finish_tx(8'h0F, 1);
        finish_tx(8'h0F, 0);

        // Fill to full with transmitter stalled, then overflow
        for (int i = 0; i < 17; i++) push(8'(8'h10 + i));
        chk("t2_full", full, 1);
        chk("t2_count16", count, 16);
        chk("t2_no_ovf_yet", overflow_tick, 0);
        push(8'hEE);
        chk("t2_ovf_pulse", overflow_tick, 1);
        chk("t2_count_still16", count, 16);
        tick();
        chk("t2_ovf_one_cycle", overflow_tick, 0);
        for (int i = 0; i < 16; i++) finish_tx(8'(8'h11 + i), 1);
        finish_tx(8'h20, 0);

        // Push on the same edge the IDLE launch pops
        for (int i = 0; i < 6; i++) push(8'(8'h30 + i));
        chk("t3_count5", count, 5);
        chk("t3_busy", busy, 1);
        repeat (17) tick();
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
        chk("t3_idle_count5", count, 5);
        wr_en   = 1'b1;
        wr_data = 8'h40;
        tick();
        wr_en   = 1'b0;
        chk("t3_start", tx_start, 1);
        chk("t3_data", tx_data, 8'h31);
        chk("t3_count_unchanged", count, 5);
        tick();
        chk("t3_pulse_end", tx_start, 0);
        for (int i = 0; i < 4; i++) finish_tx(8'(8'h32 + i), 1);
        finish_tx(8'h40, 1);
        finish_tx(8'h40, 0);

        // Stream 40 bytes, keeping the FIFO topped up to force pointer wrap
        for (int i = 0; i < 17; i++) push(8'(i));
        chk("t4_full", full, 1);
        for (int i = 0; i < 39; i++) begin
            finish_tx(8'(i + 1), 1);
            if (i + 17 < 40) push(8'(i + 17));
        end
        finish_tx(8'h27, 0);

        // Asynchronous reset mid-WAIT with 7 bytes buffered
        for (int i = 0; i < 8; i++) push(8'(8'h50 + i));
        chk("t5_count7", count, 7);
        chk("t5_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("t5_async_count", count, 0);
        chk("t5_async_empty", empty, 1);
        chk("t5_async_busy", busy, 0);
        chk("t5_async_data", tx_data, 0);
        chk("t5_async_start", tx_start, 0);
        repeat (3) tick();
        chk("t5_no_start_in_reset", tx_start, 0);
        reset = 1'b0;
        tick();
        chk("t5_no_start_after", tx_start, 0);
        chk("t5_empty_after", empty, 1);
        push(8'h81);
        tick();
        chk("t5_start81", tx_start, 1);
        chk("t5_data81", tx_data, 8'h81);
        tick();
        finish_tx(8'h81, 0);

`ifdef UART_TX_BUFFER_TIMEOUT_EN
        // Watchdog expiry with no done, next byte launches afterwards
        push(8'h91);
        push(8'h92);
        chk("to_start", tx_start, 1);
        chk("to_data", tx_data, 8'h91);
        repeat (49) tick();
        chk("to_not_yet", timeout_tick, 0);
        chk("to_busy", busy, 1);
        tick();
        chk("to_pulse", timeout_tick, 1);
        chk("to_idle", busy, 0);
        tick();
        chk("to_pulse_end", timeout_tick, 0);
        chk("to_next_start", tx_start, 1);
        chk("to_next_data", tx_data, 8'h92);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
